branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

- Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters for the pipelined MIPS core.
- Sits beside the fetch-stage PC register: it predicts the next fetch PC in the same cycle the PC is presented.
- It is trained by branch/jump resolution in the decode stage, where branches are already resolved.
- It removes the fixed one-cycle IF/ID flush on correctly predicted taken branches and jumps.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC/target width in bits; PC[1:0] ignored (word-aligned).
- ENTRIES, 16, number of table entries; power of two, 2..256.
- IDX_W, log2(ENTRIES), derived localparam, index width.
- TAG_W, ADDR_WIDTH-IDX_W-2, derived localparam, tag width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- fetch_pc  input  ADDR_WIDTH  current PC value.
- pred_taken  output  1  predict redirect.
- pred_target  output  ADDR_WIDTH  predicted next PC; valid when pred_taken=1.
- upd_valid  input  1  a branch/jump resolved in ID this cycle.
- upd_pc  input  ADDR_WIDTH  PC of the resolved instruction.
- upd_taken  input  1  actual outcome (1 for every jump/jal/jr).
- upd_target  input  ADDR_WIDTH  actual target address.
- upd_pred_taken  input  1  prediction fetch used for this instruction.
- upd_pred_target  input  ADDR_WIDTH  target fetch used.
- upd_mispredict  output  1  combinational: resolution disagrees with prediction.
- invalidate  input  1  clear all entries.
- lookup_cnt, hit_cnt, mispredict_cnt  output  32 each  present only with BTB_STATS_EN.

## Operation
- Entry fields: valid, tag[TAG_W], target[ADDR_WIDTH], ctr[2].
- Index is pc[IDX_W+1:2]; tag is pc[ADDR_WIDTH-1:IDX_W+2].
- Lookup (combinational):
  - hit = valid[idx] & (tag[idx]==fetch_pc tag).
  - pred_taken = hit & ctr[idx][1].
  - pred_target = target[idx] when hit, else 0.
- upd_mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
- Update when upd_valid=1 and invalidate=0; uhit is evaluated at upd_pc:
  - uhit & taken: ctr = min(ctr+1, 3); target = upd_target.
  - uhit & not taken: ctr = max(ctr-1, 0); target is unchanged.
  - miss & taken: allocate the entry (overwrites any resident entry); valid=1, tag written, target written, ctr=2'b10.
  - miss & not taken: no change.
- invalidate=1 clears every valid bit at the next edge. Invalidate has priority over a simultaneous update, which is discarded. Tags, targets and counters are left unchanged.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

## Timing
- Lookup has zero latency: outputs are combinational from fetch_pc and registered table state.
- Update has one-cycle latency: a write at edge N is visible to a lookup from cycle N+1.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents; there is no bypass.
- Two consecutive updates to the same entry each apply in order. Saturation holds at 3 and at 0, with no wrap.
- Reset (asynchronous, any time, including mid-update): all valid bits=0, all ctr=2'b01, tags/targets=0, stats counters=0.
  - Consequently pred_taken=0, pred_target=0 immediately.
  - upd_mispredict follows its inputs.
- Release from reset is synchronous to clk through the codebase's existing reset handling. The first update is accepted on the first edge with reset high.

## Configuration
- BTB_STATS_EN defined: adds the three 32-bit counters, each saturating at 32'hFFFF_FFFF:
  - lookup_cnt increments every cycle with reset high.
  - hit_cnt increments on every lookup hit.
  - mispredict_cnt increments when upd_mispredict=1.
  - The counters are cleared only by reset, not by invalidate.
- BTB_STATS_EN undefined: the counter ports and logic are absent. Prediction and update behaviour are identical in both builds.

## Test plan
- Reset, fetch_pc=0x0040_0010 -> pred_taken=0, pred_target=0. Release reset and repeat -> still 0.
- Update pc=0x0040_0010, taken=1, target=0x0040_0100 (pred_taken=0) -> upd_mispredict=1 that cycle. Next cycle, lookup of 0x0040_0010 -> pred_taken=1, pred_target=0x0040_0100.
- Starting from the previous entry (ctr=10): two not-taken updates give ctr 01 then 00, so pred_taken=0. Then three taken updates give 01, 10 (pred_taken=1), 11. A fourth taken update stays at 11.
- ENTRIES=16: allocate 0x0040_0010, then allocate 0x0040_0050 (same index, different tag) -> lookup of 0x0040_0010 misses and 0x0040_0050 hits.
- Same-cycle: lookup and allocating update on 0x0040_0020 -> pred_taken=0 that cycle, 1 the next. Invalidate together with an update -> the table is empty afterwards.
- BTB_STATS_EN: 10 cycles of lookups, 4 of them hits, and 2 mispredicts -> lookup_cnt=10, hit_cnt=4, mispredict_cnt=2. Asserting invalidate leaves the counts unchanged; asynchronous reset clears them.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters, read in the fetch stage.
// Define BTB_STATS_EN to add saturating lookup/hit/mispredict counters.
module branch_target_buffer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ENTRIES    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] upd_pred_target,
    output logic                  upd_mispredict,
    input  logic                  invalidate
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]           lookup_cnt,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           mispredict_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - 2;

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [ADDR_WIDTH-1:0] target;
        logic [1:0]            ctr;
    } btbEntry_t;

    btbEntry_t btbTable [ENTRIES];

    logic [IDX_W-1:0] fetchIdx;
    logic [TAG_W-1:0] fetchTag;
    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] updTag;
    btbEntry_t        fetchEntry;
    btbEntry_t        updEntry;
    logic             lookupHit;
    logic             updHit;
    logic             unusedPcBits;

    assign fetchIdx = fetch_pc[IDX_W+1:2];
    assign fetchTag = fetch_pc[ADDR_WIDTH-1:IDX_W+2];
    assign updIdx   = upd_pc[IDX_W+1:2];
    assign updTag   = upd_pc[ADDR_WIDTH-1:IDX_W+2];

    // Byte-offset bits are ignored: all PCs are word aligned.
    assign unusedPcBits = ^{fetch_pc[1:0], upd_pc[1:0]};

    // Zero-latency lookup from registered table state; no bypass from a same-cycle update.
    assign fetchEntry  = btbTable[fetchIdx];
    assign lookupHit   = fetchEntry.valid && (fetchEntry.tag == fetchTag);
    assign pred_taken  = lookupHit && fetchEntry.ctr[1];
    assign pred_target = lookupHit ? fetchEntry.target : '0;

    assign updEntry = btbTable[updIdx];
    assign updHit   = updEntry.valid && (updEntry.tag == updTag);

    assign upd_mispredict = upd_valid &&
                            ((upd_taken != upd_pred_taken) ||
                             (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

    // Training: invalidate wins over a simultaneous update, and only clears valid bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                btbTable[i].valid  <= 1'b0;
                btbTable[i].tag    <= '0;
                btbTable[i].target <= '0;
                btbTable[i].ctr    <= 2'b01;
            end
        end else if (invalidate) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                btbTable[i].valid <= 1'b0;
            end
        end else if (upd_valid) begin
            if (updHit) begin
                if (upd_taken) begin
                    btbTable[updIdx].target <= upd_target;
                    if (updEntry.ctr != 2'b11) begin
                        btbTable[updIdx].ctr <= updEntry.ctr + 2'd1;
                    end
                end else if (updEntry.ctr != 2'b00) begin
                    btbTable[updIdx].ctr <= updEntry.ctr - 2'd1;
                end
            end else if (upd_taken) begin
                btbTable[updIdx].valid  <= 1'b1;
                btbTable[updIdx].tag    <= updTag;
                btbTable[updIdx].target <= upd_target;
                btbTable[updIdx].ctr    <= 2'b10;
            end
        end
    end

`ifdef BTB_STATS_EN
    // Saturating statistics; cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lookup_cnt     <= '0;
            hit_cnt        <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (lookup_cnt != 32'hFFFF_FFFF) begin
                lookup_cnt <= lookup_cnt + 32'd1;
            end
            if (lookupHit && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (upd_mispredict && (mispredict_cnt != 32'hFFFF_FFFF)) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus randomized traffic
// checked against a per-index table model built from PC arithmetic.
module tb_branch_target_buffer;

    localparam int unsigned AW = 32;
    localparam int unsigned N  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] fetch_pc = '0;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic          upd_valid = 1'b0;
    logic [AW-1:0] upd_pc = '0;
    logic          upd_taken = 1'b0;
    logic [AW-1:0] upd_target = '0;
    logic          upd_pred_taken = 1'b0;
    logic [AW-1:0] upd_pred_target = '0;
    logic          upd_mispredict;
    logic          invalidate = 1'b0;
`ifdef BTB_STATS_EN
    logic [31:0]   lookup_cnt;
    logic [31:0]   hit_cnt;
    logic [31:0]   mispredict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_target_buffer #(.ADDR_WIDTH(AW), .ENTRIES(N)) dut (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .upd_mispredict(upd_mispredict),
        .invalidate(invalidate)
`ifdef BTB_STATS_EN
        , .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt), .mispredict_cnt(mispredict_cnt)
`endif
    );

    // Reference model: per slot, the PC that allocated it, its target and a counter 0..3.
    bit          mValid  [N];
    logic [31:0] mPc     [N];
    logic [31:0] mTarget [N];
    int          mCtr    [N];
    int unsigned sLookup, sHit, sMis;

    function automatic int unsigned slotOf(input logic [31:0] pc);
        return (pc / 4) % N;
    endfunction

    function automatic logic [31:0] tagOf(input logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    function automatic bit mHit(input logic [31:0] pc);
        return mValid[slotOf(pc)] && (tagOf(mPc[slotOf(pc)]) == tagOf(pc));
    endfunction

    function automatic bit mPredTaken(input logic [31:0] pc);
        return mHit(pc) && (mCtr[slotOf(pc)] >= 2);
    endfunction

    function automatic logic [31:0] mPredTarget(input logic [31:0] pc);
        return mHit(pc) ? mTarget[slotOf(pc)] : 32'h0;
    endfunction

    function automatic bit mMis();
        if (!upd_valid) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < int'(N); i++) begin
            mValid[i] = 1'b0; mPc[i] = '0; mTarget[i] = '0; mCtr[i] = 1;
        end
        sLookup = 0; sHit = 0; sMis = 0;
    endtask

    task automatic drive(input logic [31:0] fpc, input bit uv, input logic [31:0] upc,
                         input bit ut, input logic [31:0] utgt, input bit upt,
                         input logic [31:0] uptgt, input bit inv);
        fetch_pc = fpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt; invalidate = inv;
    endtask

    // One clock edge; the model absorbs what the DUT sees at that edge.
    task automatic tick();
        bit h, m;
        int unsigned s;
        h = mHit(fetch_pc);
        m = mMis();
        @(posedge clk);
        if (reset) begin
            sLookup++;
            if (h) sHit++;
            if (m) sMis++;
            if (invalidate) begin
                for (int i = 0; i < int'(N); i++) mValid[i] = 1'b0;
            end else if (upd_valid) begin
                s = slotOf(upd_pc);
                if (mHit(upd_pc)) begin
                    if (upd_taken) begin
                        mTarget[s] = upd_target;
                        mCtr[s] = (mCtr[s] == 3) ? 3 : mCtr[s] + 1;
                    end else begin
                        mCtr[s] = (mCtr[s] == 0) ? 0 : mCtr[s] - 1;
                    end
                end else if (upd_taken) begin
                    mValid[s] = 1'b1; mPc[s] = upd_pc; mTarget[s] = upd_target; mCtr[s] = 2;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        modelReset();
        drive(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL reset_pred got %0b/%h exp 0/0", pred_taken, pred_target);
        end
        checks++;
        if (upd_mispredict !== 1'b1) begin
            errors++; $display("FAIL reset_mispredict got %0b exp 1", upd_mispredict);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL release_pred got %0b/%h exp 0/0", pred_taken, pred_target);
        end
        tick();
    endtask

    task automatic test_allocate();
        drive(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if ({upd_mispredict, pred_taken} !== {1'b1, 1'b0}) begin
            errors++; $display("FAIL alloc_same_cycle got mis=%0b pt=%0b exp mis=1 pt=0", upd_mispredict, pred_taken);
        end
        tick();
        drive(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if ({pred_taken, pred_target} !== {1'b1, 32'h0040_0100}) begin
            errors++; $display("FAIL alloc_next got %0b/%h exp 1/00400100", pred_taken, pred_target);
        end
        tick();
    endtask

    // Counter walk from weak-taken: NT,NT reach strong-NT, four T saturate, one NT leaves weak-T.
    task automatic test_counter();
        bit seq [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 7; k++) begin
            drive(32'h0040_0010, 1'b1, 32'h0040_0010, seq[k], 32'h0040_0100,
                  mPredTaken(32'h0040_0010), mPredTarget(32'h0040_0010), 1'b0);
            #1;
            checks++;
            if ({pred_taken, pred_target} !== {mPredTaken(fetch_pc), mPredTarget(fetch_pc)}) begin
                errors++; $display("FAIL counter_step%0d got %0b/%h exp %0b/%h", k, pred_taken,
                                   pred_target, mPredTaken(fetch_pc), mPredTarget(fetch_pc));
            end
            tick();
        end
        drive(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++; $display("FAIL counter_saturate got %0b exp 1", pred_taken);
        end
    endtask

    task automatic test_alias();
        drive(32'h0, 1'b1, 32'h0040_0050, 1'b1, 32'h0040_0200, 1'b0, 32'h0, 1'b0);
        tick();
        drive(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL alias_old got %0b/%h exp 0/0", pred_taken, pred_target);
        end
        fetch_pc = 32'h0040_0050;
        #1;
        checks++;
        if ({pred_taken, pred_target} !== {1'b1, 32'h0040_0200}) begin
            errors++; $display("FAIL alias_new got %0b/%h exp 1/00400200", pred_taken, pred_target);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        drive(32'h0040_0020, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0300, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL same_cycle_pre got %0b exp 0", pred_taken);
        end
        tick();
        drive(32'h0040_0020, 1'b1, 32'h0040_0030, 1'b1, 32'h0040_0400, 1'b0, 32'h0, 1'b1);
        #1;
        checks++;
        if ({pred_taken, pred_target} !== {1'b1, 32'h0040_0300}) begin
            errors++; $display("FAIL same_cycle_post got %0b/%h exp 1/00400300", pred_taken, pred_target);
        end
        tick();
        drive(32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL invalidate_old got %0b exp 0", pred_taken);
        end
        fetch_pc = 32'h0040_0030;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL invalidate_discard got %0b exp 0", pred_taken);
        end
        tick();
    endtask

    task automatic test_async_reset();
        drive(32'h0040_0040, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0500, 1'b0, 32'h0, 1'b0);
        tick();
        drive(32'h0040_0040, 1'b1, 32'h0040_0044, 1'b1, 32'h0040_0600, 1'b0, 32'h0, 1'b0);
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checks++;
        if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL async_reset got %0b/%h exp 0/0", pred_taken, pred_target);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(32'h0040_0040, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        logic [31:0] fpc, upc, tgt, ptgt;
        bit uv, ut, upt, inv;
        for (int n = 0; n < 400; n++) begin
            fpc  = 32'h0040_0000 + 32'($urandom_range(0, 63)) * 32'd4;
            upc  = 32'h0040_0000 + 32'($urandom_range(0, 63)) * 32'd4;
            tgt  = 32'($urandom) & 32'hFFFF_FFFC;
            ptgt = ($urandom_range(0, 1) == 0) ? tgt : (32'($urandom) & 32'hFFFF_FFFC);
            uv   = ($urandom_range(0, 3) != 0);
            ut   = ($urandom_range(0, 2) != 0);
            upt  = 1'($urandom_range(0, 1));
            inv  = ($urandom_range(0, 39) == 0);
            drive(fpc, uv, upc, ut, tgt, upt, ptgt, inv);
            #1;
            checks++;
            if ({pred_taken, pred_target} !== {mPredTaken(fpc), mPredTarget(fpc)}) begin
                errors++; $display("FAIL random_pred n=%0d pc=%h got %0b/%h exp %0b/%h", n, fpc,
                                   pred_taken, pred_target, mPredTaken(fpc), mPredTarget(fpc));
            end
            checks++;
            if (upd_mispredict !== mMis()) begin
                errors++; $display("FAIL random_mispredict n=%0d got %0b exp %0b", n, upd_mispredict, mMis());
            end
            tick();
        end
`ifdef BTB_STATS_EN
        checks++;
        if ({lookup_cnt, hit_cnt, mispredict_cnt} !== {sLookup, sHit, sMis}) begin
            errors++; $display("FAIL random_stats got %0d/%0d/%0d exp %0d/%0d/%0d", lookup_cnt,
                               hit_cnt, mispredict_cnt, sLookup, sHit, sMis);
        end
`endif
    endtask

`ifdef BTB_STATS_EN
    // 10 lookups: 4 hits on A and 2 mispredicting updates.
    task automatic test_stats();
        #2;
        reset = 1'b0;
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        drive(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b0);
        tick();
        drive(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0104, 1'b0);
        tick();
        drive(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        drive(32'h0000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if ({lookup_cnt, hit_cnt, mispredict_cnt} !== {32'd10, 32'd4, 32'd2}) begin
            errors++; $display("FAIL stats_counts got %0d/%0d/%0d exp 10/4/2", lookup_cnt, hit_cnt, mispredict_cnt);
        end
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        checks++;
        if ({lookup_cnt, hit_cnt, mispredict_cnt} !== {32'd11, 32'd4, 32'd2}) begin
            errors++; $display("FAIL stats_invalidate got %0d/%0d/%0d exp 11/4/2", lookup_cnt, hit_cnt, mispredict_cnt);
        end
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checks++;
        if ({lookup_cnt, hit_cnt, mispredict_cnt} !== {32'd0, 32'd0, 32'd0}) begin
            errors++; $display("FAIL stats_reset got %0d/%0d/%0d exp 0/0/0", lookup_cnt, hit_cnt, mispredict_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_same_cycle();
        test_async_reset();
        test_random();
`ifdef BTB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
